// File: rtl/flags_access_arbiter_pkg.sv
// Shared types and helpers for the flags PIO access arbiter.
// The new-word function is 32 bits wide; narrower flag words are zero-extended into it.
package flags_arb_pkg;

    localparam int FLAG_W_DEFAULT = 32;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RDW,
        ST_RSP
    } state_e;

    function automatic logic [FLAG_W_DEFAULT-1:0] calc_new(
        input logic [1:0]                op,
        input logic [FLAG_W_DEFAULT-1:0] shadow,
        input logic [FLAG_W_DEFAULT-1:0] mask,
        input logic [FLAG_W_DEFAULT-1:0] data
    );
        logic [FLAG_W_DEFAULT-1:0] result;
        case (op)
            OP_WRITE: result = (shadow & ~mask) | (data & mask);
            OP_SET:   result = shadow | mask;
            OP_CLEAR: result = shadow & ~mask;
            default:  result = shadow;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/flags_rr_arbiter.sv
// Combinational round-robin picker: the first requester above last_grant (with wrap) wins.
module flags_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest one overwrites.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        if (enable) begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
                if (req[cand]) begin
                    grant       = '0;
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

endmodule

// File: rtl/flags_access_arbiter.sv
// Serialises masked set/clear/write and reads from NUM_REQ requesters onto the flags PIO,
// keeping a shadow of the PIO output word so masked updates need no read-back.
module flags_access_arbiter
    import flags_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FLAG_W  = FLAG_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [FLAG_W*NUM_REQ-1:0] req_mask,
    input  logic [FLAG_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [FLAG_W-1:0]         rsp_data,
    output logic [1:0]                avm_address,
    output logic                      avm_chipselect,
    output logic                      avm_write_n,
    output logic [FLAG_W-1:0]         avm_writedata,
    input  logic [FLAG_W-1:0]         avm_readdata,
    output logic [FLAG_W-1:0]         shadow_out,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e state, state_next;

    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               accept;

    logic [IDX_W-1:0]  gnt_idx;
    logic [1:0]        op_r;
    logic [FLAG_W-1:0] mask_r;
    logic [FLAG_W-1:0] data_r;
    logic [FLAG_W-1:0] shadow;
    logic [FLAG_W-1:0] rsp_data_r;
    logic [FLAG_W-1:0] new_word;

    logic [1:0]        op_arr   [NUM_REQ];
    logic [FLAG_W-1:0] mask_arr [NUM_REQ];
    logic [FLAG_W-1:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_arr[i]   = req_op[2*i +: 2];
        assign mask_arr[i] = req_mask[FLAG_W*i +: FLAG_W];
        assign data_arr[i] = req_data[FLAG_W*i +: FLAG_W];
    end

    flags_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .enable     ((state == ST_IDLE) && !reset),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign accept    = |grant;
    assign req_ready = grant;

    assign new_word = FLAG_W'(calc_new(op_r, FLAG_W_DEFAULT'(shadow),
                                       FLAG_W_DEFAULT'(mask_r), FLAG_W_DEFAULT'(data_r)));

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_next = (op_arr[grant_idx] == OP_READ) ? ST_RD : ST_WR;
            end
            ST_WR:   state_next = ST_RSP;
            ST_RD:   state_next = ST_RDW;
            ST_RDW:  state_next = ST_RSP;
            ST_RSP:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = shadow;
        case (state)
            ST_WR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = new_word;
            end
            ST_RD:   avm_chipselect = 1'b1;
            default: ;
        endcase
    end

    // A reset landing on RSP must not leak a completion pulse.
    always_comb begin
        rsp_valid = '0;
        if ((state == ST_RSP) && !reset)
            rsp_valid[gnt_idx] = 1'b1;
    end

    assign avm_address = 2'b00;
    assign rsp_data    = rsp_data_r;
    assign shadow_out  = shadow;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            shadow     <= '0;
            rsp_data_r <= '0;
        end else begin
            state <= state_next;
            if (accept)
                last_grant <= grant_idx;
            if (state == ST_WR) begin
                shadow     <= new_word;
                rsp_data_r <= new_word;
            end
            if (state == ST_RDW)
                rsp_data_r <= avm_readdata;
        end
    end

    // Request payload is captured only in the accept cycle; it is meaningless until then.
    always_ff @(posedge clk) begin
        if (accept) begin
            gnt_idx <= grant_idx;
            op_r    <= op_arr[grant_idx];
            mask_r  <= mask_arr[grant_idx];
            data_r  <= data_arr[grant_idx];
        end
    end

endmodule

// File: tb/tb_flags_access_arbiter.sv
// Directed bench for flags_access_arbiter with a response/bus scoreboard and a PIO read model.
module tb_flags_access_arbiter;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] req_valid;
    logic [2*NR-1:0]  req_op;
    logic [32*NR-1:0] req_mask;
    logic [32*NR-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic [NR-1:0] rsp_valid;
    logic [31:0]   rsp_data;
    logic [1:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [31:0]   avm_writedata;
    logic [31:0]   avm_readdata;
    logic [31:0]   shadow_out;
    logic          busy;

    logic [1:0]  op_a   [NR];
    logic [31:0] mask_a [NR];
    logic [31:0] data_a [NR];
    logic [31:0] pio_in;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic [31:0] shadow;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        is_wr;
        logic [31:0] data;
        int          cyc;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];
    int   acc_idx[$];
    int   acc_cyc[$];
    logic [31:0] model_sh = 32'h0;
    logic [31:0] nw;

    flags_access_arbiter #(.NUM_REQ(NR), .FLAG_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_mask       (req_mask),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .shadow_out     (shadow_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PIO input register: data appears one cycle after being presented.
    always @(posedge clk) avm_readdata <= pio_in;

    always_comb begin
        req_op   = '0;
        req_mask = '0;
        req_data = '0;
        for (int i = 0; i < NR; i++) begin
            req_op[2*i +: 2]    = op_a[i];
            req_mask[32*i +: 32] = mask_a[i];
            req_data[32*i +: 32] = data_a[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept monitor: predicts the bus cycle and the response for every accepted request.
    always @(negedge clk) begin
        if (!reset && req_ready !== '0) begin
            check("ready_onehot", 32'($countones(req_ready)), 32'd1);
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) begin
                    check("ready_valid", {31'b0, req_valid[i]}, 32'd1);
                    acc_idx.push_back(i);
                    acc_cyc.push_back(cyc);
                    if (op_a[i] == 2'b11) begin
                        bus_q.push_back('{1'b0, 32'h0, cyc + 1});
                        rsp_q.push_back('{i, pio_in, model_sh, cyc + 3});
                    end else begin
                        case (op_a[i])
                            2'b00:   nw = (model_sh & ~mask_a[i]) | (data_a[i] & mask_a[i]);
                            2'b01:   nw = model_sh | mask_a[i];
                            default: nw = model_sh & ~mask_a[i];
                        endcase
                        bus_q.push_back('{1'b1, nw, cyc + 1});
                        rsp_q.push_back('{i, nw, nw, cyc + 2});
                        model_sh = nw;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bus_t b;
        if (avm_chipselect === 1'b1) begin
            if (bus_q.size() == 0) begin
                check("bus_unexpected", {31'b0, avm_chipselect}, 32'd0);
            end else begin
                b = bus_q.pop_front();
                check("bus_cycle", 32'(cyc), 32'(b.cyc));
                check("bus_write_n", {31'b0, avm_write_n}, {31'b0, ~b.is_wr});
                check("bus_address", {30'b0, avm_address}, 32'd0);
                if (b.is_wr)
                    check("bus_writedata", avm_writedata, b.data);
            end
        end
    end

    always @(negedge clk) begin
        rsp_t r;
        if (rsp_valid !== '0) begin
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", {28'b0, rsp_valid}, 32'd0);
            end else begin
                r = rsp_q.pop_front();
                check("rsp_onehot", {28'b0, rsp_valid}, 32'd1 << r.idx);
                check("rsp_data", rsp_data, r.data);
                check("rsp_shadow", shadow_out, r.shadow);
                check("rsp_latency", 32'(cyc), 32'(r.cyc));
            end
        end
    end

    task automatic issue(input int i, input logic [1:0] op, input logic [31:0] m, input logic [31:0] d);
        int n = 0;
        @(posedge clk); #1;
        op_a[i] = op;
        mask_a[i] = m;
        data_a[i] = d;
        req_valid[i] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 20);
        check("accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0 || busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        rsp_q.delete();
        model_sh = 32'h0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        req_valid = '0;
        pio_in = 32'h0;
        for (int i = 0; i < NR; i++) begin
            op_a[i] = 2'b00;
            mask_a[i] = 32'h0;
            data_a[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_shadow", shadow_out, 32'h0);
        check("rst_cs", {31'b0, avm_chipselect}, 32'd0);
        check("rst_write_n", {31'b0, avm_write_n}, 32'd1);
        check("rst_writedata", avm_writedata, 32'h0);
        check("rst_rsp_valid", {28'b0, rsp_valid}, 32'd0);
        check("rst_req_ready", {28'b0, req_ready}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);

        // Single SET from reset
        issue(0, 2'b01, 32'h0000_00F0, 32'h0);
        drain();
        check("set_shadow", shadow_out, 32'h0000_00F0);

        // Masked WRITE then CLEAR
        issue(1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_0000);
        drain();
        issue(1, 2'b00, 32'h0000_FFFF, 32'h1234_5678);
        drain();
        check("write_shadow", shadow_out, 32'hFFFF_5678);
        issue(1, 2'b10, 32'hFF00_0000, 32'h0);
        drain();
        check("clear_shadow", shadow_out, 32'h00FF_5678);

        // READ
        pio_in = 32'hA5A5_0001;
        issue(2, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        check("read_rsp_data", rsp_data, 32'hA5A5_0001);
        check("read_shadow", shadow_out, 32'h00FF_5678);

        // Contention from a fresh reset
        pulse_reset();
        acc_idx.delete();
        acc_cyc.delete();
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            op_a[i] = 2'b01;
            mask_a[i] = 32'h1 << (8 * i);
        end
        req_valid = 4'hF;
        begin
            int n = 0;
            while (acc_idx.size() < 5 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("contend_timeout", 32'(n < 40), 32'd1);
        end
        @(posedge clk); #1;
        req_valid = '0;
        drain();
        if (acc_idx.size() >= 5) begin
            int exp_order[5] = '{0, 1, 2, 3, 0};
            for (int k = 0; k < 5; k++)
                check("contend_order", 32'(acc_idx[k]), 32'(exp_order[k]));
            for (int k = 1; k < 5; k++)
                check("contend_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
        end
        check("contend_shadow", shadow_out, 32'h0101_0101);

        // Reset landing on the WR cycle
        issue(3, 2'b01, 32'h0000_000F, 32'h0);
        reset = 1'b1;
        rsp_q.delete();
        model_sh = 32'h0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_shadow", shadow_out, 32'h0);
        check("midrst_cs", {31'b0, avm_chipselect}, 32'd0);
        check("midrst_rsp_valid", {28'b0, rsp_valid}, 32'd0);
        issue(1, 2'b01, 32'h0000_0003, 32'h0);
        drain();
        check("postrst_shadow", shadow_out, 32'h0000_0003);

        // mask=0 SET still issues a write of the unchanged shadow
        issue(0, 2'b01, 32'h0, 32'h0);
        drain();
        check("mask0_shadow", shadow_out, 32'h0000_0003);
        check("mask0_rsp_data", rsp_data, 32'h0000_0003);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flags_access_arbiter.md
Name: flags_access_arbiter

Overview:
- Shares the 32-bit flags PIO Avalon-MM slave between NUM_REQ on-chip requesters, e.g. stepper, endstop and heater FSMs.
- The PIO only supports full-word writes. This block keeps a shadow copy of the PIO output word, so atomic masked set, clear and write operations become single PIO writes without read-back.
- It also serialises reads of the PIO input word.
- Sits between the FPGA-side motion logic and the flags PIO; it is the PIO's only FPGA-side Avalon master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FLAG_W, 32, flags word width; must match the PIO.

Ports:
- clk  in  1  system clock, shared with the PIO.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held until accepted.
- req_op  in  2*NUM_REQ  per-requester opcode; slice i is [2i+1:2i].
- req_mask  in  FLAG_W*NUM_REQ  per-requester bit mask.
- req_data  in  FLAG_W*NUM_REQ  per-requester write data.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- rsp_data  out  FLAG_W  completion data; valid while any rsp_valid bit is high.
- avm_address  out  2  PIO address; always 0.
- avm_chipselect  out  1  PIO chipselect.
- avm_write_n  out  1  PIO write strobe, active low.
- avm_writedata  out  FLAG_W  PIO write data.
- avm_readdata  in  FLAG_W  PIO read data; registered in the PIO, valid 1 cycle after address is presented.
- shadow_out  out  FLAG_W  current shadow of the PIO output word.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Opcodes:
  - 00 WRITE: new = (shadow & ~mask) | (data & mask).
  - 01 SET: new = shadow | mask.
  - 10 CLEAR: new = shadow & ~mask.
  - 11 READ: sample the PIO input word; mask and data are ignored.
- FSM states: IDLE, WR, RD, RDW, RSP. Transitions:
  - IDLE -> WR if any req_valid and the granted op is not READ.
  - IDLE -> RD if any req_valid and the granted op is READ.
  - IDLE -> IDLE if no req_valid.
  - WR -> RSP.
  - RD -> RDW.
  - RDW -> RSP.
  - RSP -> IDLE, unconditionally.
- Arbitration (IDLE only):
  - Round-robin, searching from last_grant+1 upward with wrap-around.
  - In the same cycle: req_ready[g] is driven high (combinational), and grant index, op, mask and data are registered.
  - last_grant updates on accept.
  - Requesters not granted keep req_valid asserted. Opcode, mask and data are sampled only in the accept cycle.
- WR:
  - avm_chipselect=1, avm_write_n=0, avm_writedata=new.
  - shadow <= new at the end of the cycle.
  - rsp_data register <= new.
- RD: avm_chipselect=1, avm_write_n=1, avm_address=0.
- RDW: rsp_data register <= avm_readdata.
- RSP: rsp_valid[g]=1 for exactly one cycle; rsp_data holds its value.
- Outside WR and RD: avm_chipselect=0, avm_write_n=1, avm_writedata=shadow.
- Latency from the accept cycle to rsp_valid: 2 cycles for write ops, 3 cycles for READ.
- Throughput: the next accept happens in the IDLE cycle immediately after RSP.
- A write is always issued, even when mask=0 or new equals shadow; nothing is suppressed.
- req_valid of the requester currently being serviced is ignored until the FSM returns to IDLE.
- A requester may drop req_valid before accept; no ready pulse is issued to it in that case.
- Reset values, all synchronous:
  - state=IDLE.
  - last_grant=NUM_REQ-1, so req 0 has priority on the first arbitration.
  - shadow=0, matching the PIO reset value of 0.
  - rsp_data=0, rsp_valid=0, req_ready=0, busy=0.
  - avm_chipselect=0, avm_write_n=1, avm_writedata=0.
- Reset mid-operation: the transaction is abandoned and no rsp_valid pulse is issued. clk and reset are shared with the PIO, so the PIO is reset to the same 0 state as the shadow.

Decomposition:
- flags_arb_pkg holds:
  - opcode constants OP_WRITE/OP_SET/OP_CLEAR/OP_READ;
  - the state enum;
  - FLAG_W default;
  - a function computing new from op, shadow, mask and data.
- Sub-module flags_rr_arbiter: NUM_REQ-wide round-robin picker.
  - Inputs: req vector, last_grant, enable.
  - Outputs: one-hot grant and grant index. Purely combinational; last_grant register stays in the parent.

Test Plan:
- Single SET: req0 SET mask=0x0000_00F0 from reset -> req_ready[0] in cycle 0; WR in cycle 1 with writedata=0x0000_00F0; rsp_valid[0] in cycle 2; rsp_data=0x0000_00F0; shadow_out=0x0000_00F0.
- Masked WRITE then CLEAR: shadow=0xFFFF_0000; req1 WRITE mask=0x0000_FFFF data=0x1234_5678 -> writedata=0xFFFF_5678. Then req1 CLEAR mask=0xFF00_0000 -> writedata=0x00FF_5678.
- READ: in_port=0xA5A5_0001; req2 READ -> chipselect with write_n=1 in cycle 1; rsp_valid[2] in cycle 3; rsp_data=0xA5A5_0001; shadow unchanged.
- Contention: req0..3 all valid continuously with SET ops -> grant order 0,1,2,3,0; each rsp 2 cycles after its accept; accepts 3 cycles apart.
- Reset mid-op: assert reset during WR -> next cycle IDLE, shadow=0, chipselect=0, no rsp_valid; a fresh request is accepted normally afterwards.
- mask=0 SET -> write still issued with writedata=shadow; rsp_valid asserted; shadow unchanged.
